par_to_serial: RTL and testbench
================================

PAR_TO_SERIAL -- requirements
Module: par_to_serial

Interface
REQ-001 The block SHALL take parameter BITS, default 8, as the parallel word width (BITS >= 2).
REQ-002 The block SHALL take parameter IDLE_WORD [BITS-1:0], default 8'hBC, as the filler pattern sent when no data is available.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 data_in  input  BITS  parallel word to transmit.
REQ-006 valid_in  input  1  data_in holds a word to send.
REQ-007 ready_out  output  1  block accepts data_in this cycle.
REQ-008 data_out  output  1  serial bit stream, registered.
REQ-009 sync_out  output  1  high on the first bit slot of every frame, registered.
REQ-010 data_flag  output  1  high for every bit slot of a data frame, low for idle frames, registered.

Function
REQ-011 Frame length SHALL be F = BITS slots (BITS+1 with parity, see REQ-024); frames follow back-to-back with no gap slots.
REQ-012 A bit counter SHALL run 0..F-1 and wrap to 0; slot 0 is the frame's first bit.
REQ-013 ready_out SHALL equal (bit counter == F-1) AND NOT reset; it is high exactly one cycle per frame.
REQ-014 A word SHALL be accepted on a rising edge where valid_in and ready_out are both high; data_in is captured into the shift register on that edge.
REQ-015 valid_in while ready_out is low SHALL be ignored; data_in is not sampled and no state changes.
REQ-016 Latency: after the accepting edge, data_out SHALL present data_in[BITS-1] in the next cycle, then descending bits, LSB in slot BITS-1.
REQ-017 On a ready_out edge with valid_in low, the next frame SHALL be IDLE_WORD, MSB first, with data_flag low.
REQ-018 sync_out SHALL be high in slot 0 of both data and idle frames and low otherwise.
REQ-019 data_flag SHALL be constant across all F slots of a frame.
REQ-020 Continuous valid_in SHALL give continuous data frames at full rate, one word per F cycles.

Reset
REQ-021 While reset is high, data_out, sync_out, data_flag and ready_out SHALL be 0; the bit counter SHALL be F-1 and the shift register 0.
REQ-022 The first cycle after reset release SHALL have ready_out high, so the next frame is data or idle per REQ-014/017.
REQ-023 Reset asserted mid-frame SHALL abort the frame at the next edge; the partial word is discarded and not resent.

Configuration
REQ-024 With macro PAR_TO_SERIAL_PARITY_EN defined, F = BITS+1 and slot BITS SHALL carry even parity (XOR of the BITS word bits) for data and idle frames; ready_out is high during the parity slot.
REQ-025 Without PAR_TO_SERIAL_PARITY_EN, F = BITS, no parity slot is generated and no parity logic is present.

Verification (BITS=8, IDLE_WORD=8'hBC, parity off unless stated)
REQ-026 Reset 2 cycles, valid_in=0 -> data_out repeats 1,0,1,1,1,1,0,0; sync_out every 8th cycle; data_flag=0; ready_out one cycle in 8.
REQ-027 Present 8'hA5 with valid_in at first ready_out -> next 8 cycles data_out 1,0,1,0,0,1,0,1, data_flag=1, sync_out in slot 0; idle frame follows.
REQ-028 valid_in held, words 8'h3C then 8'hFF on successive ready_out cycles -> 16 contiguous data slots 0,0,1,1,1,1,0,0,1,1,1,1,1,1,1,1 with no idle slot between.
REQ-029 valid_in=1 with data_in changing while ready_out=0 -> no capture; only the value present at the ready_out edge is sent.
REQ-030 Reset asserted during slot 4 of a data frame -> all outputs 0 next cycle; after release ready_out=1 at once and a fresh frame starts.
REQ-031 PARITY_EN defined: send 8'hA5 then 8'h07 -> 9-slot frames, parity slot 0 then 1; idle frame parity slot 1 (8'hBC has five ones).

Source files
------------

// File: rtl/par_to_serial.sv
// par_to_serial: parallel-to-serial framer. Sends one BITS-wide word per
// frame, MSB first, with a sync strobe on the first slot and a data flag
// that marks data frames. When no word is offered at a frame boundary, an
// idle pattern (IDLE_WORD) is sent instead so the serial line never gaps.
// Optional build macro PAR_TO_SERIAL_PARITY_EN appends an even-parity slot
// to every frame (data and idle alike).
module par_to_serial #(
  parameter int              BITS      = 8,
  parameter logic [BITS-1:0] IDLE_WORD = BITS'(8'hBC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] data_in,
  input  logic            valid_in,
  output logic            ready_out,
  output logic            data_out,
  output logic            sync_out,
  output logic            data_flag
);

`ifdef PAR_TO_SERIAL_PARITY_EN
  localparam int F = BITS + 1;
`else
  localparam int F = BITS;
`endif
  localparam int CW = (F > 1) ? $clog2(F) : 1;
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic            dout_q, dout_d;
  logic            sync_q, sync_d;
  logic            flag_q, flag_d;
  logic [BITS-1:0] word;
`ifdef PAR_TO_SERIAL_PARITY_EN
  logic            par_q, par_d;
`endif

  // The last slot of every frame is the hand-off point for the next word.
  assign ready_out = (cnt_q == LAST) && !reset;
  assign data_out  = dout_q;
  assign sync_out  = sync_q;
  assign data_flag = flag_q;

  // Next-state: load a new frame on the hand-off slot, otherwise shift out.
  always_comb begin
    word    = valid_in ? data_in : IDLE_WORD;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    sync_d  = sync_q;
    flag_d  = flag_q;
`ifdef PAR_TO_SERIAL_PARITY_EN
    par_d   = par_q;
`endif
    if (ready_out) begin
      // MSB goes straight to the output register; the rest waits in shreg.
      cnt_d   = '0;
      dout_d  = word[BITS-1];
      shreg_d = {word[BITS-2:0], 1'b0};
      sync_d  = 1'b1;
      flag_d  = valid_in;
`ifdef PAR_TO_SERIAL_PARITY_EN
      par_d   = ^word;
`endif
    end else begin
      cnt_d  = cnt_q + CW'(1);
      sync_d = 1'b0;
`ifdef PAR_TO_SERIAL_PARITY_EN
      if (cnt_q == CW'(BITS - 1)) begin
        dout_d = par_q;
      end else begin
        dout_d  = shreg_q[BITS-1];
        shreg_d = {shreg_q[BITS-2:0], 1'b0};
      end
`else
      dout_d  = shreg_q[BITS-1];
      shreg_d = {shreg_q[BITS-2:0], 1'b0};
`endif
    end
  end

  // State registers; reset parks the counter on the hand-off slot so the
  // first cycle after release can accept a word immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= LAST;
      shreg_q <= '0;
      dout_q  <= 1'b0;
      sync_q  <= 1'b0;
      flag_q  <= 1'b0;
`ifdef PAR_TO_SERIAL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      sync_q  <= sync_d;
      flag_q  <= flag_d;
`ifdef PAR_TO_SERIAL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_par_to_serial.sv
// Directed bench for par_to_serial (BITS=8, IDLE_WORD=8'hBC). Expected
// serial bits are derived from the word being sent; frame length follows
// PAR_TO_SERIAL_PARITY_EN when the bench is built with it.
module tb_par_to_serial;

  localparam int BITS = 8;
  localparam logic [BITS-1:0] IDLE = 8'hBC;
`ifdef PAR_TO_SERIAL_PARITY_EN
  localparam int F = BITS + 1;
`else
  localparam int F = BITS;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [BITS-1:0] data_in;
  logic            valid_in;
  logic            ready_out;
  logic            data_out;
  logic            sync_out;
  logic            data_flag;

  int total  = 0;
  int passed = 0;

  par_to_serial #(.BITS(BITS), .IDLE_WORD(IDLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .sync_out  (sync_out),
    .data_flag (data_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask

  // Called at a point where ready_out is high. Offers (word, vld), crosses
  // the accepting edge, then checks nslots slots at the falling edge.
  // mode 0: drop valid after accept; 1: hold valid and data;
  // 2: keep valid high with changing data while ready_out is low.
  task automatic send_frame(input logic [BITS-1:0] word, input logic vld,
                            input int nslots, input int mode);
    logic [BITS-1:0] w;
    logic            eb;
    w        = vld ? word : IDLE;
    data_in  = word;
    valid_in = vld;
    @(posedge clk);
    for (int k = 0; k < nslots; k++) begin
      @(negedge clk);
      eb = (k < BITS) ? w[BITS-1-k] : ^w;
      chk($sformatf("w%02h_s%0d_data", w, k), data_out, eb);
      chk($sformatf("w%02h_s%0d_sync", w, k), sync_out, k == 0);
      chk($sformatf("w%02h_s%0d_flag", w, k), data_flag, vld);
      chk($sformatf("w%02h_s%0d_rdy", w, k), ready_out, k == F - 1);
      if (k < F - 1) begin
        if (mode == 0) begin
          valid_in = 1'b0;
        end else if (mode == 2) begin
          valid_in = 1'b1;
          data_in  = BITS'($urandom);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;

    // Reset held two cycles: everything low, including ready_out.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data_out, 1'b0);
    chk("rst_sync", sync_out, 1'b0);
    chk("rst_flag", data_flag, 1'b0);
    chk("rst_rdy", ready_out, 1'b0);

    // Release: ready_out is high in the very first cycle.
    reset = 1'b0;
    #1;
    chk("rel_rdy", ready_out, 1'b1);

    // Idle stream: 1,0,1,1,1,1,0,0 repeating, data_flag low.
    send_frame(8'h00, 1'b0, F, 0);
    send_frame(8'h00, 1'b0, F, 0);

    // Single data word followed by an idle frame.
    send_frame(8'hA5, 1'b1, F, 0);
    send_frame(8'h00, 1'b0, F, 0);

    // Back-to-back words with valid held: no idle slot between them.
    send_frame(8'h3C, 1'b1, F, 1);
    send_frame(8'hFF, 1'b1, F, 1);
    send_frame(8'h07, 1'b1, F, 0);

    // Changing data with valid high while not ready: only the word present
    // on the ready edge is sent.
    send_frame(8'h3C, 1'b1, F, 2);
    send_frame(8'h81, 1'b1, F, 0);

    // Reset in slot 4 of a data frame aborts it.
    send_frame(8'hA5, 1'b1, 5, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_data", data_out, 1'b0);
    chk("mid_rst_sync", sync_out, 1'b0);
    chk("mid_rst_flag", data_flag, 1'b0);
    chk("mid_rst_rdy", ready_out, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rel_rdy", ready_out, 1'b1);
    chk("mid_rel_data", data_out, 1'b0);

    // Fresh frame after abort, then idle.
    send_frame(8'hC3, 1'b1, F, 0);
    send_frame(8'h00, 1'b0, F, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
